// File: rtl/race_lane_arbiter_pkg.sv
// Shared definitions for the race-track lane arbiter: FSM encodings and parameter defaults.
// Latency: none (definitions only).
// Backpressure: none (definitions only).
package race_lane_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RELEASE = 2'd2,
        ST_ACK     = 2'd3
    } state_t;

    localparam int DEF_N_LANES        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 64;

    // Index width for a lane number; a single-lane build still needs one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/race_lane_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; valid is low when no request is set.
module rr_pick
    import race_lane_arbiter_pkg::*;
#(
    parameter int N = DEF_N_LANES,
    parameter int W = ptr_width(DEF_N_LANES)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         valid
);

    localparam logic [W:0] N_EXT = (W+1)'(N);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [W-1:0]   offs;
    logic [W:0]     sum;

    // Rotate so ptr sits at bit 0, take the lowest set bit, then rotate the index back.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        valid = |req;
        offs  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                offs = W'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offs};
        if (sum >= N_EXT) begin
            sum = sum - N_EXT;
        end
        winner = sum[W-1:0];
    end

endmodule

// File: rtl/race_lane_arbiter.sv
// Round-robin arbiter sharing one start/done race track among N_LANES lanes; RACE_TIMEOUT_EN adds a RUN watchdog.
// Latency: grant/start one cycle after req is sampled in IDLE; ack one cycle after done falls (or watchdog expiry).
// Backpressure: lanes hold req until ack; stale done in IDLE blocks new grants; requests are not latched while busy.
module race_lane_arbiter
    import race_lane_arbiter_pkg::*;
#(
    parameter int N_LANES        = DEF_N_LANES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_LANES-1:0] req,
    output logic [N_LANES-1:0] grant,
    output logic [N_LANES-1:0] ack,
    output logic               start,
    input  logic               done,
    output logic               busy,
    output logic               timeout
);

    localparam int PTR_W = ptr_width(N_LANES);
    localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_LANES);

    if (N_LANES < 1 || N_LANES > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("race_lane_arbiter: N_LANES must be 1..16 and TIMEOUT_CYCLES >= 1");
    end

    state_t             state_q, state_d;
    logic [N_LANES-1:0] grant_q, grant_d;
    logic [N_LANES-1:0] ack_q, ack_d;
    logic               start_q, start_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_vld;
    logic [PTR_W:0]     win_inc;
    logic [PTR_W-1:0]   ptr_nxt;

`ifdef RACE_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    rr_pick #(.N(N_LANES), .W(PTR_W)) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_idx),
        .valid  (pick_vld)
    );

    // Pointer moves to the lane just after the one that finished its race.
    assign win_inc = {1'b0, win_q} + 1'b1;
    assign ptr_nxt = (win_inc >= N_EXT) ? '0 : win_inc[PTR_W-1:0];

    // Next-state and output logic for the grant / four-phase start-done / ack sequence.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ack_d   = '0;
        start_d = start_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
`ifdef RACE_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                // A done left high by the track must clear before a new race starts.
                if (pick_vld && !done) begin
                    win_d   = pick_idx;
                    grant_d = N_LANES'(1) << pick_idx;
                    start_d = 1'b1;
                    state_d = ST_RUN;
`ifdef RACE_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            ST_RUN: begin
                // done is checked first so it wins over a watchdog expiry on the same edge.
                if (done) begin
                    start_d = 1'b0;
                    state_d = ST_RELEASE;
                end
`ifdef RACE_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    start_d   = 1'b0;
                    ack_d     = grant_q;
                    timeout_d = 1'b1;
                    grant_d   = '0;
                    ptr_d     = ptr_nxt;
                    state_d   = ST_ACK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_RELEASE: begin
                if (!done) begin
                    ack_d   = grant_q;
                    grant_d = '0;
                    ptr_d   = ptr_nxt;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                // Requests are ignored here so the acked lane has an edge to drop req.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            ptr_q   <= '0;
            win_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            start_q <= start_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
        end
    end

`ifdef RACE_TIMEOUT_EN
    // Watchdog counter and timeout pulse register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign grant = grant_q;
    assign ack   = ack_q;
    assign start = start_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_race_lane_arbiter.sv
// Self-checking bench for race_lane_arbiter: directed scenarios plus randomized traffic against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_race_lane_arbiter;

    localparam int N = 4;
    localparam int T = 8;
`ifdef RACE_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = 4'b1111;
    logic         done = 1'b0;
    logic [N-1:0] grant;
    logic [N-1:0] ack;
    logic         start;
    logic         busy;
    logic         timeout;

    always #5 clk = ~clk;

    race_lane_arbiter #(.N_LANES(N), .TIMEOUT_CYCLES(T)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .grant   (grant),
        .ack     (ack),
        .start   (start),
        .done    (done),
        .busy    (busy),
        .timeout (timeout)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int oh2idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // ---------------- behavioural model: who owns the track, who is being acked ----------------
    int m_owner = -1;   // lane currently holding grant, -1 if none
    int m_ack   = -1;   // lane being acknowledged this cycle, -1 if none
    int m_ptr   = 0;
    int m_run   = 0;    // cycles spent with start high in the current race
    bit m_start = 1'b0;
    bit m_to    = 1'b0;

    always @(posedge clk) begin
        if (!rst) begin
            m_owner = -1; m_ack = -1; m_ptr = 0; m_run = 0; m_start = 1'b0; m_to = 1'b0;
        end else if (m_ack >= 0) begin
            m_ack = -1;
            m_to  = 1'b0;
        end else if (m_owner < 0) begin
            if (req != '0 && !done) begin
                for (int i = 0; i < N; i++) begin
                    if (req[(m_ptr + i) % N]) begin
                        m_owner = (m_ptr + i) % N;
                        break;
                    end
                end
                m_start = 1'b1;
                m_run   = 0;
            end
        end else if (m_start) begin
            m_run++;
            if (done) begin
                m_start = 1'b0;
            end else if (TO_EN && m_run >= T) begin
                m_start = 1'b0;
                m_ack   = m_owner;
                m_to    = 1'b1;
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else if (!done) begin
            m_ack   = m_owner;
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
    end

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clk) begin
        logic [N-1:0] eg;
        logic [N-1:0] ea;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        ea = (m_ack >= 0) ? (N'(1) << m_ack) : '0;
        chk("cyc_grant", 32'(grant), 32'(eg));
        chk("cyc_ack", 32'(ack), 32'(ea));
        chk("cyc_start", 32'(start), 32'(m_start));
        chk("cyc_busy", 32'(busy), 32'((m_owner >= 0) || (m_ack >= 0)));
        chk("cyc_timeout", 32'(timeout), 32'(m_to));
    end

    // ---------------- monitor: grant order and ack counts ----------------
    int           gseq[$];
    int           ack_cnt[N];
    logic [N-1:0] seen_grant = '0;
    logic [N-1:0] prev_grant = '0;

    always begin
        @(posedge clk);
        #1;
        if (grant != '0 && prev_grant == '0) gseq.push_back(oh2idx(grant));
        for (int i = 0; i < N; i++) begin
            if (ack[i]) ack_cnt[i]++;
        end
        seen_grant = seen_grant | grant;
        prev_grant = grant;
    end

    task automatic clear_mon();
        gseq.delete();
        for (int i = 0; i < N; i++) ack_cnt[i] = 0;
        seen_grant = '0;
    endtask

    // ---------------- track responder ----------------
    bit trk_auto = 1'b1;
    int rise_d = 3;
    int fall_d = 1;
    int rcnt = 0;
    int fcnt = 0;

    always @(negedge clk) begin
        if (trk_auto) begin
            if (start && !done) begin
                rcnt++;
                if (rcnt >= rise_d) begin done = 1'b1; rcnt = 0; end
            end else if (!start && done) begin
                fcnt++;
                if (fcnt >= fall_d) begin done = 1'b0; fcnt = 0; end
            end else begin
                rcnt = 0; fcnt = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        clear_mon();
    endtask

    task automatic wait_grants(input int n, input int budget, input string name);
        int c = 0;
        while (gseq.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        chk(name, 32'(gseq.size() >= n), 32'd1);
    endtask

    initial begin
        int n;
        // Reset with all lanes requesting.
        cyc(3);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_ack", 32'(ack), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        clear_mon();
        @(negedge clk);
        chk("first_grant", 32'(grant), 32'h1);
        chk("first_start", 32'(start), 32'd1);

        // Round-robin order with every lane requesting.
        wait_grants(5, 200, "rr_progress");
        if (gseq.size() >= 5) begin
            chk("rr_g0", 32'(gseq[0]), 32'd0);
            chk("rr_g1", 32'(gseq[1]), 32'd1);
            chk("rr_g2", 32'(gseq[2]), 32'd2);
            chk("rr_g3", 32'(gseq[3]), 32'd3);
            chk("rr_g4", 32'(gseq[4]), 32'd0);
        end
        for (int i = 0; i < N; i++) chk("rr_acks", 32'(ack_cnt[i]), 32'd1);

        // Reset while a race is running, then arbitration restarts at lane 0.
        n = 0;
        while (!(start && !done) && n < 50) begin @(negedge clk); n++; end
        chk("mid_in_run", 32'(start), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        chk("mid_start", 32'(start), 32'd0);
        chk("mid_grant", 32'(grant), 32'd0);
        rst = 1'b1;
        clear_mon();
        wait_grants(1, 50, "mid_regrant");
        if (gseq.size() >= 1) chk("mid_lane0", 32'(gseq[0]), 32'd0);

        // Sparse requests: only lanes 1 and 3.
        req = 4'b1010;
        do_reset();
        wait_grants(4, 300, "sparse_progress");
        if (gseq.size() >= 4) begin
            chk("sp_g0", 32'(gseq[0]), 32'd1);
            chk("sp_g1", 32'(gseq[1]), 32'd3);
            chk("sp_g2", 32'(gseq[2]), 32'd1);
            chk("sp_g3", 32'(gseq[3]), 32'd3);
        end
        chk("sp_never", 32'(seen_grant & 4'b0101), 32'd0);
        chk("sp_ack0", 32'(ack_cnt[0]), 32'd0);
        chk("sp_ack2", 32'(ack_cnt[2]), 32'd0);

        // Stale done in IDLE blocks the grant until it falls.
        req = 4'b0000;
        do_reset();
        trk_auto = 1'b0;
        done = 1'b1;
        req = 4'b0001;
        cyc(5);
        chk("stale_start", 32'(start), 32'd0);
        chk("stale_busy", 32'(busy), 32'd0);
        done = 1'b0;
        @(negedge clk);
        chk("stale_release", 32'(start), 32'd1);
        chk("stale_grant", 32'(grant), 32'h1);
        rcnt = 0; fcnt = 0;
        trk_auto = 1'b1;
        n = 0;
        while (ack_cnt[0] == 0 && n < 50) begin @(negedge clk); n++; end
        chk("stale_acked", 32'(ack_cnt[0]), 32'd1);

`ifdef RACE_TIMEOUT_EN
        // Track never answers: watchdog aborts after T RUN cycles.
        req = 4'b0000;
        trk_auto = 1'b0;
        done = 1'b0;
        do_reset();
        req = 4'b0011;
        n = 0;
        while (!start && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (start && n < 50) begin n++; @(negedge clk); end
        chk("to_run_len", 32'(n), 32'(T));
        chk("to_ack", 32'(ack), 32'h1);
        chk("to_pulse", 32'(timeout), 32'd1);
        @(negedge clk);
        chk("to_ack_end", 32'(ack), 32'd0);
        chk("to_pulse_end", 32'(timeout), 32'd0);
        @(negedge clk);
        chk("to_next", 32'(grant), 32'h2);
        rcnt = 0; fcnt = 0;
        trk_auto = 1'b1;
`endif

        // Randomized traffic checked cycle by cycle against the model.
        req = 4'b0000;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 399) == 0) rst = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    if ($urandom_range(0, 3) != 0) req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 7) == 0) req[i] = 1'b1;
                end else if ($urandom_range(0, 63) == 0) begin
                    req[i] = 1'b0;
                end
            end
            if ($urandom_range(0, 15) == 0) begin
                rise_d = $urandom_range(1, 10);
                fall_d = $urandom_range(1, 4);
            end
            if (!busy && !start && $urandom_range(0, 39) == 0) done = 1'b1;
        end
        rst = 1'b1;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench timeout");
    end

endmodule
